// File: rtl/i2s_audio_rx_if.sv
// I2S receive bundle: codec pins and configuration level in, captured stereo pair and strobes out.
interface i2s_audio_rx_if #(
    parameter int unsigned WL = 32
);
    logic          cfg_done;
    logic          aud_bclk;
    logic          aud_lrc;
    logic          aud_adcdat;
    logic [WL-1:0] rx_l_data;
    logic [WL-1:0] rx_r_data;
    logic          rx_done;
    logic          frame_err;

    modport master (
        output cfg_done, aud_bclk, aud_lrc, aud_adcdat,
        input  rx_l_data, rx_r_data, rx_done, frame_err
    );

    modport slave (
        input  cfg_done, aud_bclk, aud_lrc, aud_adcdat,
        output rx_l_data, rx_r_data, rx_done, frame_err
    );
endinterface

// File: rtl/i2s_audio_rx.sv
// WM8978 I2S ADC receiver: oversamples BCLK/LRC/DAT in the system clock domain and
// presents each completed left/right word pair with a one-cycle rx_done strobe.
module i2s_audio_rx #(
    parameter int unsigned WL = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    i2s_audio_rx_if.slave rx_if
);
    localparam int unsigned CW = $clog2(WL + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_SHIFT, ST_HOLD} state_e;

    state_e        state_q, state_d;
    logic [1:0]    bclk_sync_q, lrc_sync_q, dat_sync_q;
    logic          bclk_prev_q, lrc_smp_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WL-1:0] sr_q, sr_d;
    logic          chan_q, chan_d;
    logic [WL-1:0] l_shadow_q, l_shadow_d;
    logic          l_valid_q, l_valid_d;
    logic [WL-1:0] rx_l_q, rx_l_d;
    logic [WL-1:0] rx_r_q, rx_r_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          bclk_rise_c, lrc_now_c, dat_now_c, lrc_edge_c, lrc_fall_c;
    logic [WL-1:0] word_c;
    logic [CW-1:0] cnt_inc_c;
    logic          word_end_c;

    // Synchronisers, BCLK edge detector and the per-bit LRC sample used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync_q <= '0;
            lrc_sync_q  <= '0;
            dat_sync_q  <= '0;
            bclk_prev_q <= 1'b0;
            lrc_smp_q   <= 1'b0;
        end else begin
            bclk_sync_q <= {bclk_sync_q[0], rx_if.aud_bclk};
            lrc_sync_q  <= {lrc_sync_q[0], rx_if.aud_lrc};
            dat_sync_q  <= {dat_sync_q[0], rx_if.aud_adcdat};
            bclk_prev_q <= bclk_sync_q[1];
            if (bclk_rise_c) lrc_smp_q <= lrc_now_c;
        end
    end

    assign bclk_rise_c = bclk_sync_q[1] & ~bclk_prev_q;
    assign lrc_now_c   = lrc_sync_q[1];
    assign dat_now_c   = dat_sync_q[1];
    assign lrc_edge_c  = bclk_rise_c & (lrc_now_c ^ lrc_smp_q);
    assign lrc_fall_c  = lrc_edge_c & ~lrc_now_c;
    assign cnt_inc_c   = cnt_q + CW'(1);

    // Current bit lands at position WL-1-count, so a short slot stays left-aligned and zero-filled.
    always_comb begin
        word_c = sr_q;
        for (int unsigned i = 0; i < WL; i++) begin
            if ((cnt_q < CW'(WL)) && (CW'(i) == (CW'(WL - 1) - cnt_q))) word_c[i] = dat_now_c;
        end
    end

    // DELAY is entered on the LRC-edge rise, whose bit is the previous slot's LSB;
    // the following rise carries the MSB. The bit on a slot-ending edge rise belongs to that slot.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        chan_d     = chan_q;
        l_shadow_d = l_shadow_q;
        l_valid_d  = l_valid_q;
        rx_l_d     = rx_l_q;
        rx_r_d     = rx_r_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        word_end_c = 1'b0;

        if (!rx_if.cfg_done) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            sr_d      = '0;
            l_valid_d = 1'b0;
        end else if (bclk_rise_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (lrc_fall_c) begin
                        state_d = ST_DELAY;
                        chan_d  = 1'b0;
                        cnt_d   = '0;
                        sr_d    = '0;
                    end
                end
                ST_DELAY, ST_SHIFT: begin
                    sr_d       = word_c;
                    cnt_d      = cnt_inc_c;
                    state_d    = (cnt_inc_c == CW'(WL)) ? ST_HOLD : ST_SHIFT;
                    word_end_c = lrc_edge_c || (cnt_inc_c == CW'(WL));
                    err_d      = lrc_edge_c && (cnt_inc_c < CW'(WL));
                end
                ST_HOLD: state_d = ST_HOLD;
                default: state_d = ST_IDLE;
            endcase

            if ((state_q != ST_IDLE) && lrc_edge_c) begin
                state_d = ST_DELAY;
                chan_d  = lrc_now_c;
                cnt_d   = '0;
                sr_d    = '0;
            end

            // A right word only forms a pair when this frame's left word already completed.
            if (word_end_c) begin
                if (!chan_q) begin
                    l_shadow_d = word_c;
                    l_valid_d  = 1'b1;
                end else begin
                    if (l_valid_q) begin
                        rx_l_d = l_shadow_q;
                        rx_r_d = word_c;
                        done_d = 1'b1;
                    end
                    l_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            chan_q     <= 1'b0;
            l_shadow_q <= '0;
            l_valid_q  <= 1'b0;
            rx_l_q     <= '0;
            rx_r_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            chan_q     <= chan_d;
            l_shadow_q <= l_shadow_d;
            l_valid_q  <= l_valid_d;
            rx_l_q     <= rx_l_d;
            rx_r_q     <= rx_r_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_if.rx_l_data = rx_l_q;
    assign rx_if.rx_r_data = rx_r_q;
    assign rx_if.rx_done   = done_q;
    assign rx_if.frame_err = err_q;
endmodule
